// File: rtl/store_buffer.sv
// Store buffer between MEM-stage store/load requests and a single-port data memory.
// Define STBUF_FWD_EN to forward buffered store data to loads; otherwise matching loads stall.
module store_buffer #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned MATCH_W      = 5,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_st_valid,
  input  logic [31:0]              i_st_addr,
  input  logic [31:0]              i_st_data,
  output logic                     o_st_ready,
  input  logic                     i_ld_valid,
  input  logic [31:0]              i_ld_addr,
  output logic [31:0]              o_ld_data,
  output logic                     o_ld_stall,
  output logic                     o_mem_we,
  output logic                     o_mem_re,
  output logic [31:0]              o_mem_addr,
  output logic [31:0]              o_mem_wdata,
  input  logic [31:0]              i_mem_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [31:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;

  logic w_full;
  logic w_nonempty;
  logic w_starved;
  logic w_push;
  logic w_drain;
  logic w_ld_win;
  logic w_force;
  logic w_fwd_hit;
`ifdef STBUF_FWD_EN
  logic [31:0] w_fwd_data;
`endif

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_nonempty = (r_count != '0);
  assign w_starved  = (r_starve == SW'(STARVE_LIMIT));
  assign o_st_ready = !i_reset && !w_full;
  assign w_push     = i_st_valid && o_st_ready;
  assign o_count    = r_count;
  assign o_empty    = (r_count == '0);

  // Walk from oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    w_fwd_hit  = 1'b0;
`ifdef STBUF_FWD_EN
    w_fwd_data = '0;
`endif
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < r_count) &&
          (r_addr[r_head + PW'(k)][MATCH_W-1:0] == i_ld_addr[MATCH_W-1:0])) begin
        w_fwd_hit  = 1'b1;
`ifdef STBUF_FWD_EN
        w_fwd_data = r_data[r_head + PW'(k)];
`endif
      end
    end
  end

`ifdef STBUF_FWD_EN
  assign w_force = w_nonempty && (w_full || w_starved);
`else
  // Without forwarding, a load hitting the buffer must wait until the entry reaches memory.
  assign w_force = w_nonempty && (w_full || w_starved || (i_ld_valid && w_fwd_hit));
`endif

  always_comb begin
    w_drain     = 1'b0;
    w_ld_win    = 1'b0;
    o_ld_stall  = 1'b0;
    o_ld_data   = '0;
    o_mem_we    = 1'b0;
    o_mem_re    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (!i_reset) begin
      if (w_force) begin
        w_drain    = 1'b1;
        o_ld_stall = i_ld_valid;
      end else if (i_ld_valid) begin
        w_ld_win   = 1'b1;
        o_mem_re   = 1'b1;
        o_mem_addr = i_ld_addr;
`ifdef STBUF_FWD_EN
        o_ld_data  = w_fwd_hit ? w_fwd_data : i_mem_rdata;
`else
        o_ld_data  = i_mem_rdata;
`endif
      end else if (w_nonempty) begin
        w_drain = 1'b1;
      end
      if (w_drain) begin
        o_mem_we    = 1'b1;
        o_mem_addr  = r_addr[r_head];
        o_mem_wdata = r_data[r_head];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_drain) r_head <= r_head + PW'(1);
      if (w_push && !w_drain) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_drain) begin
        r_count <= r_count - CW'(1);
      end
      if (w_drain || !w_nonempty) begin
        r_starve <= '0;
      end else if (w_ld_win && !w_starved) begin
        r_starve <= r_starve + SW'(1);
      end
    end
  end

  // Entry storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_addr[r_tail] <= i_st_addr;
      r_data[r_tail] <= i_st_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic vs a queue model.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [2:0]  count;
  logic        empty;

  always #5 clk = ~clk;

  store_buffer #(
    .DEPTH       (DEPTH),
    .MATCH_W     (5),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_st_valid (st_valid),
    .i_st_addr  (st_addr),
    .i_st_data  (st_data),
    .o_st_ready (st_ready),
    .i_ld_valid (ld_valid),
    .i_ld_addr  (ld_addr),
    .o_ld_data  (ld_data),
    .o_ld_stall (ld_stall),
    .o_mem_we   (mem_we),
    .o_mem_re   (mem_re),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata),
    .o_count    (count),
    .o_empty    (empty)
  );

  // Physical memory driven by the DUT.
  logic [31:0] mem [32];
  assign mem_rdata = mem[mem_addr[4:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[4:0]] <= mem_wdata;

  // Reference model state.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;
  ent_t        q[$];
  logic [31:0] mem_m [32];
  int          starve;
  bit          e_stall;
  bit          e_ready;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, compare against the model, advance the model past the edge.
  task automatic step(input logic rst, input logic stv, input logic [31:0] sta,
                      input logic [31:0] std, input logic ldv, input logic [31:0] lda);
    bit          hit;
    bit          force_d;
    bit          drain;
    bit          re;
    logic [31:0] e_ld;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    int          sz;
    @(negedge clk);
    reset    = rst;
    st_valid = stv;
    st_addr  = sta;
    st_data  = std;
    ld_valid = ldv;
    ld_addr  = lda;
    #1;
    sz      = q.size();
    hit     = 0;
    e_ld    = '0;
    for (int i = sz - 1; i >= 0; i--) begin
      if (!hit && q[i].a[4:0] == lda[4:0]) begin
        hit = 1;
`ifdef STBUF_FWD_EN
        e_ld = q[i].d;
`endif
      end
    end
`ifdef STBUF_FWD_EN
    force_d = sz > 0 && (sz == DEPTH || starve == LIMIT);
`else
    force_d = sz > 0 && (sz == DEPTH || starve == LIMIT || (ldv && hit));
`endif
    e_ready = !rst && sz < DEPTH;
    drain   = 0;
    re      = 0;
    e_stall = 0;
    if (!rst) begin
      if (force_d) begin
        drain   = 1;
        e_stall = ldv;
      end else if (ldv) begin
        re = 1;
        if (!hit) e_ld = mem_m[lda[4:0]];
      end else if (sz > 0) begin
        drain = 1;
      end
    end
    if (!re) e_ld = '0;
    e_addr  = drain ? q[0].a : (re ? lda : 32'h0);
    e_wdata = drain ? q[0].d : 32'h0;
    check_eq("st_ready", st_ready, e_ready);
    check_eq("ld_stall", ld_stall, e_stall);
    check_eq("ld_data", ld_data, e_ld);
    check_eq("mem_we", mem_we, drain);
    check_eq("mem_re", mem_re, re);
    check_eq("mem_addr", mem_addr, e_addr);
    check_eq("mem_wdata", mem_wdata, e_wdata);
    check_eq("count", count, sz);
    check_eq("empty", empty, sz == 0);
    if (rst) begin
      q.delete();
      starve = 0;
    end else begin
      if (drain) begin
        mem_m[q[0].a[4:0]] = q[0].d;
        void'(q.pop_front());
      end
      if (drain || sz == 0) starve = 0;
      else if (re && starve < LIMIT) starve++;
      if (stv && e_ready) q.push_back('{a: sta, d: std});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] v3;
    bit          pend_st;
    logic [31:0] p_sa;
    logic [31:0] p_sd;
    bit          pend_ld;
    logic [31:0] p_la;
    for (int i = 0; i < 32; i++) begin
      mem[i]   = $urandom;
      mem_m[i] = mem[i];
    end
    reset    = 1'b1;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    repeat (2) @(negedge clk);
    q.delete();
    starve = 0;

    // Reset outputs.
    step(1, 1, 32'd9, 32'd9, 1, 32'd9);
    check_eq("rst_ready", st_ready, 0);

    // Three stores drain in order.
    step(0, 1, 32'd4, 32'd11, 0, 0);
    step(0, 1, 32'd8, 32'd22, 0, 0);
    check_eq("t1_first_drain", mem_wdata, 32'd11);
    step(0, 1, 32'd12, 32'd33, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_eq("t1_last_drain", mem_wdata, 32'd33);
    step(0, 0, 0, 0, 0, 0);
    check_eq("t1_empty", empty, 1);

    // Load right behind a store to the same address.
    step(0, 1, 32'd5, 32'hAA, 0, 0);
    step(0, 0, 0, 0, 1, 32'd5);
`ifdef STBUF_FWD_EN
    check_eq("t2_fwd", ld_data, 32'hAA);
`else
    check_eq("t2_stall", ld_stall, 1);
    step(0, 0, 0, 0, 1, 32'd5);
    check_eq("t2_after", ld_data, 32'hAA);
`endif
    idle(3);

    // Youngest of two matching entries.
    step(0, 1, 32'd7, 32'd1, 1, 32'd30);
    step(0, 1, 32'd7, 32'd2, 1, 32'd30);
    step(0, 0, 0, 0, 1, 32'd7);
`ifndef STBUF_FWD_EN
    step(0, 0, 0, 0, 1, 32'd7);
    step(0, 0, 0, 0, 1, 32'd7);
`endif
    check_eq("t3_youngest", ld_data, 32'd2);
    idle(4);

    // Fill under continuous loads.
    for (int i = 0; i < 4; i++) step(0, 1, 32'd8 + i, i, 1, 32'd30);
    step(0, 1, 32'd12, 32'd99, 1, 32'd30);
    check_eq("t4_not_ready", st_ready, 0);
    check_eq("t4_stall", ld_stall, 1);
    step(0, 0, 0, 0, 1, 32'd30);
    check_eq("t4_count", count, 3);
    idle(5);

    // Starvation forces a drain on the fourth load cycle.
    step(0, 1, 32'd20, 32'h55, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 32'd1);
      check_eq("t5_stall", ld_stall, i == 3);
    end
    idle(2);

    // Reset discards held stores.
    v3 = mem_m[3];
    step(0, 1, 32'd3, 32'hDEAD, 1, 32'd30);
    step(0, 1, 32'd4, 32'hBEEF, 1, 32'd30);
    step(1, 0, 0, 0, 1, 32'd30);
    check_eq("t6_no_we", mem_we, 0);
    step(0, 0, 0, 0, 0, 0);
    check_eq("t6_count", count, 0);
    step(0, 0, 0, 0, 1, 32'd3);
    check_eq("t6_mem", ld_data, v3);

    // Random traffic.
    pend_st = 0;
    pend_ld = 0;
    p_sa    = '0;
    p_sd    = '0;
    p_la    = '0;
    for (int c = 0; c < 3000; c++) begin
      bit rst;
      rst = ($urandom_range(0, 149) == 0);
      if (!pend_st && $urandom_range(0, 9) < 4) begin
        pend_st = 1;
        p_sa    = {$urandom_range(0, 3), 25'h0, 5'($urandom_range(0, 7))};
        p_sd    = $urandom;
      end
      if (!pend_ld && $urandom_range(0, 9) < 6) begin
        pend_ld = 1;
        p_la    = {$urandom_range(0, 3), 25'h0, 5'($urandom_range(0, 7))};
      end
      step(rst, pend_st, p_sa, p_sd, pend_ld, p_la);
      if (rst || e_ready) pend_st = 0;
      if (rst || !e_stall) pend_ld = 0;
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
